// File: rtl/game_defs.sv
// game_defs -- shared definitions for the game state controller and the
// display path.
//
// Contents:
//   game_state_e : state encoding (IDLE=00, PLAY=01, WIN=10, LOSE=11)
//   msg_sel_e    : message select codes (00 title, 01 win, 10 lose)
//   layer_en_t   : bundle of display-mixer layer enables
//   layer_enables(): steady-state layer enables for a given game state
package game_defs;

  localparam int TIME_W = 7;
  localparam int COIN_W = 4;
  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    MSG_TITLE = 2'b00,
    MSG_WIN   = 2'b01,
    MSG_LOSE  = 2'b10
  } msg_sel_e;

  typedef struct packed {
    logic back_en;
    logic char_en;
    logic coin_en;
    logic mess_en;
    logic timer_en;
  } layer_en_t;

  // Steady-state enables per state. In WIN/LOSE mess_en is the non-blinking
  // value; the controller overrides it when blinking is built in.
  function automatic layer_en_t layer_enables(input game_state_e st);
    layer_en_t en;
    en = '{back_en: 1'b1, char_en: 1'b0, coin_en: 1'b0,
           mess_en: 1'b1, timer_en: 1'b0};
    case (st)
      ST_PLAY: begin
        en.char_en  = 1'b1;
        en.coin_en  = 1'b1;
        en.mess_en  = 1'b0;
        en.timer_en = 1'b1;
      end
      ST_WIN, ST_LOSE: begin
        en.timer_en = 1'b1;
      end
      default: ;
    endcase
    return en;
  endfunction

  function automatic msg_sel_e msg_for_state(input game_state_e st);
    case (st)
      ST_WIN:  return MSG_WIN;
      ST_LOSE: return MSG_LOSE;
      default: return MSG_TITLE;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler -- divides clk down to a one-cycle game tick.
//
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset (counter -> 0)
//   clear : restart the count so the next tick is DIV cycles away
//   tick  : high for one cycle every DIV cycles
module tick_prescaler #(
  parameter int DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl -- top-level game flow controller: IDLE -> PLAY -> WIN/LOSE
// -> IDLE, with a countdown timer, coin counter and display layer enables.
//
// Parameters: TICK_DIV (clk cycles per tick), TIME_INIT (countdown start),
//             COIN_GOAL (coins to win), HOLD_TICKS (ticks shown in WIN/LOSE).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start, coin_hit       : single-cycle requests (start in IDLE, coins in PLAY)
//   back_en .. timer_en   : registered layer enables to the display mixer
//   msg_sel               : registered message select
//   time_left, coins      : registered game counters
//   state                 : registered game state
// Build option: define MSG_BLINK_EN to make mess_en blink once per tick in
// WIN/LOSE; otherwise mess_en is steady 1 there.
module game_state_ctrl
  import game_defs::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int TIME_INIT  = 60,
  parameter int COIN_GOAL  = 10,
  parameter int HOLD_TICKS = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              coin_hit,
  output logic              back_en,
  output logic              char_en,
  output logic              coin_en,
  output logic              mess_en,
  output logic              timer_en,
  output logic [1:0]        msg_sel,
  output logic [TIME_W-1:0] time_left,
  output logic [COIN_W-1:0] coins,
  output logic [1:0]        state
);

  localparam logic [TIME_W-1:0] TIME_START = TIME_W'(TIME_INIT);
  localparam logic [COIN_W-1:0] GOAL       = COIN_W'(COIN_GOAL);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);

  game_state_e       state_q, state_d;
  logic [TIME_W-1:0] time_left_q, time_left_d;
  logic [COIN_W-1:0] coins_q, coins_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  layer_en_t         en_q, en_d;
  msg_sel_e          msg_sel_q, msg_sel_d;
  logic              tick;
  logic              state_change;

  // Restarting the prescaler on every state change makes each state's first
  // tick land exactly TICK_DIV cycles after entry.
  tick_prescaler #(
    .DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(state_change),
    .tick (tick)
  );

  assign state_change = (state_d != state_q);

  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    coins_d     = coins_q;
    hold_d      = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_PLAY;
          time_left_d = TIME_START;
          coins_d     = '0;
        end
      end

      ST_PLAY: begin
        // Exit decisions use the registered counters, so a goal coin and the
        // expiring tick landing together both show up here at once and the
        // coin check wins. Counters freeze on the exit cycle.
        if (coins_q == GOAL) begin
          state_d = ST_WIN;
          hold_d  = '0;
        end else if (time_left_q == '0) begin
          state_d = ST_LOSE;
          hold_d  = '0;
        end else begin
          if (tick && (time_left_q != '0)) begin
            time_left_d = time_left_q - TIME_W'(1);
          end
          if (coin_hit && (coins_q != GOAL)) begin
            coins_d = coins_q + COIN_W'(1);
          end
        end
      end

      ST_WIN, ST_LOSE: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef MSG_BLINK_EN
  logic blink_q, blink_d;

  // Blink phase: 1 on entering any state, toggled by each tick in WIN/LOSE.
  always_comb begin
    blink_d = blink_q;
    if (state_change) begin
      blink_d = 1'b1;
    end else if (tick && ((state_q == ST_WIN) || (state_q == ST_LOSE))) begin
      blink_d = ~blink_q;
    end
  end

  always_comb begin
    en_d = layer_enables(state_d);
    if ((state_d == ST_WIN) || (state_d == ST_LOSE)) begin
      en_d.mess_en = blink_d;
    end
    msg_sel_d = msg_for_state(state_d);
  end
`else
  always_comb begin
    en_d      = layer_enables(state_d);
    msg_sel_d = msg_for_state(state_d);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      time_left_q <= TIME_START;
      coins_q     <= '0;
      hold_q      <= '0;
      en_q        <= layer_enables(ST_IDLE);
      msg_sel_q   <= MSG_TITLE;
`ifdef MSG_BLINK_EN
      blink_q     <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      time_left_q <= time_left_d;
      coins_q     <= coins_d;
      hold_q      <= hold_d;
      en_q        <= en_d;
      msg_sel_q   <= msg_sel_d;
`ifdef MSG_BLINK_EN
      blink_q     <= blink_d;
`endif
    end
  end

  assign back_en   = en_q.back_en;
  assign char_en   = en_q.char_en;
  assign coin_en   = en_q.coin_en;
  assign mess_en   = en_q.mess_en;
  assign timer_en  = en_q.timer_en;
  assign msg_sel   = msg_sel_q;
  assign time_left = time_left_q;
  assign coins     = coins_q;
  assign state     = state_q;

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, clk cycles per game tick (1 s at 50 MHz); legal range 2 or more.
REQ-002 The block SHALL have parameter TIME_INIT, default 60, countdown start value in ticks; legal range 1-127.
REQ-003 The block SHALL have parameter COIN_GOAL, default 10, coins needed to win; legal range 1-15.
REQ-004 The block SHALL have parameter HOLD_TICKS, default 5, ticks spent in WIN/LOSE before returning to IDLE; legal range 1-15.
REQ-005 The block SHALL have port clk, input, 1 bit: system clock; the block uses one clock only.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: single-cycle start request.
REQ-008 The block SHALL have port coin_hit, input, 1 bit: single-cycle pulse when the character collects a coin.
REQ-009 The block SHALL have ports back_en, char_en, coin_en, mess_en and timer_en, each an output of 1 bit: layer enables to the display mixer.
REQ-010 The block SHALL have port msg_sel, output, 2 bits: message select (00 title, 01 win, 10 lose).
REQ-011 The block SHALL have port time_left, output, 7 bits: remaining ticks.
REQ-012 The block SHALL have port coins, output, 4 bits: coins collected.
REQ-013 The block SHALL have port state, output, 2 bits: IDLE=00, PLAY=01, WIN=10, LOSE=11.

Function
REQ-014 All outputs SHALL be registered; each output change SHALL appear in the clk cycle after the event that causes it.
REQ-015 A prescaler SHALL assert an internal one-cycle tick every TICK_DIV cycles; it SHALL clear on every state entry.
REQ-016 In IDLE, outputs SHALL be back_en=1, mess_en=1, msg_sel=00, and all other enables 0.
REQ-017 IDLE + start SHALL transition to PLAY, loading time_left=TIME_INIT and coins=0.
REQ-018 In PLAY, outputs SHALL be back_en, char_en, coin_en and timer_en =1, and mess_en=0.
REQ-019 In PLAY, each tick SHALL decrement time_left, saturating at 0.
REQ-020 In PLAY, each coin_hit SHALL increment coins, saturating at COIN_GOAL.
REQ-021 PLAY SHALL transition to WIN when coins reaches COIN_GOAL.
REQ-022 PLAY SHALL transition to LOSE when time_left reaches 0.
REQ-023 If coin_hit reaches the goal in the same cycle that a tick makes time_left 0, the next state SHALL be WIN.
REQ-024 In WIN and LOSE, outputs SHALL be back_en=1, timer_en=1, mess_en=1, and char_en=coin_en=0; msg_sel SHALL be 01 in WIN and 10 in LOSE.
REQ-025 In WIN and LOSE, time_left and coins SHALL hold frozen.
REQ-026 WIN/LOSE SHALL transition to IDLE after HOLD_TICKS ticks; time_left and coins SHALL hold until the next start.
REQ-027 start SHALL be ignored outside IDLE; coin_hit SHALL be ignored outside PLAY.

Reset
REQ-028 reset SHALL force state=IDLE, time_left=TIME_INIT, coins=0, prescaler=0 and hold counter=0, with outputs per REQ-016, on the next clk edge.
REQ-029 reset SHALL take priority over start, coin_hit and tick in the same cycle, including mid-PLAY and mid-hold.

Configuration
REQ-030 When MSG_BLINK_EN is defined, mess_en SHALL be 1 on entry to WIN/LOSE and toggle on every tick while in those states.
REQ-031 When MSG_BLINK_EN is undefined, mess_en SHALL be steady 1 in WIN/LOSE and no blink logic SHALL be present.

Structure
REQ-032 State encodings and msg_sel codes SHALL be defined in a shared include file, game_defs, used by this block and the display path.
REQ-033 The prescaler SHALL be a sub-module named tick_prescaler, with parameter DIV and ports clk, reset, clear and tick.

Verification (TICK_DIV=4, TIME_INIT=3, COIN_GOAL=2, HOLD_TICKS=2)
REQ-034 The bench SHALL cover: reset, then idle 20 cycles -> state=00, mess_en=1, msg_sel=00, time_left=3, coins=0.
REQ-035 The bench SHALL cover: start, then no coins -> time_left 3,2,1,0 at 4-cycle spacing; state=11 and msg_sel=10 one cycle after 0; state=00 after 2 further ticks.
REQ-036 The bench SHALL cover: start, then coin_hit twice -> coins=2, state=10, char_en=0, time_left frozen.
REQ-037 The bench SHALL cover: second coin_hit on the same cycle as the expiring tick -> state=10 (WIN priority).
REQ-038 The bench SHALL cover: reset asserted mid-PLAY with coin_hit high -> next cycle state=00, coins=0, time_left=3.
REQ-039 The bench SHALL cover: with MSG_BLINK_EN defined, WIN -> mess_en sequence 1,0 across 2 ticks, then IDLE with mess_en=1; start during WIN ignored.
